// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side blocks.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PKT_LEN    = 4;

    function automatic int idx_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream of fifo_stream_reader.
interface fifo_stream_reader_if import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  fifo_rd_en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_d_out;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_d_out,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_d_out,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry registered buffer; entry0 is always the head of the queue.
module fifo_skid_buf import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            cnt
);
    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;

    // The caller never loads a full buffer nor pops an empty one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            cnt    <= 2'd0;
        end else begin
            case ({load, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        entry0 <= load_data;
                    end else begin
                        entry1 <= load_data;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        entry0 <= load_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = entry0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the synchronous FIFO and re-emits words as a packetised valid/ready stream.
// Optional beat/stall counters are built when FIFO_STREAM_READER_STATS_EN is defined.
module fifo_stream_reader import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PKT_LEN    = DEF_PKT_LEN
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    fifo_stream_reader_if.master        bus,
    output logic                        idle
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output logic [15:0]                 stat_words,
    output logic [15:0]                 stat_stall
`endif
);
    localparam int              IDX_W   = idx_width(PKT_LEN);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PKT_LEN - 1);

    rd_state_e             state;
    rd_state_e             state_nxt;
    logic [1:0]            buf_cnt;
    logic                  inflight;
    logic [IDX_W-1:0]      fetch_idx;
    logic [IDX_W-1:0]      out_idx;
    logic                  beat;
    logic                  fetch_allow;
    logic                  space_ok;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] head_data;

    assign beat      = bus.m_valid && bus.m_ready;
    assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight};
    // space >= 1 rewritten as occupancy <= 1 + beat to stay unsigned
    assign space_ok  = occupancy <= (3'd1 + {2'b00, beat});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fetch_allow = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                fetch_allow = 1'b1;
                if (!en) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                fetch_allow = (fetch_idx != '0);
                if (en) begin
                    state_nxt = RUN;
                end else if (fetch_idx == '0 && !inflight && buf_cnt == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.fifo_rd_en = fetch_allow && !bus.fifo_empty && space_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight  <= 1'b0;
            fetch_idx <= '0;
            out_idx   <= '0;
        end else begin
            inflight <= bus.fifo_rd_en;
            if (bus.fifo_rd_en) begin
                fetch_idx <= (fetch_idx == IDX_MAX) ? '0 : fetch_idx + IDX_W'(1);
            end
            if (beat) begin
                out_idx <= (out_idx == IDX_MAX) ? '0 : out_idx + IDX_W'(1);
            end
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (inflight),
        .load_data (bus.fifo_d_out),
        .pop       (beat),
        .head_data (head_data),
        .cnt       (buf_cnt)
    );

    assign bus.m_valid = (buf_cnt != 2'd0);
    assign bus.m_data  = head_data;
    assign bus.m_last  = bus.m_valid && (out_idx == IDX_MAX);
    assign idle        = (state == IDLE);

`ifdef FIFO_STREAM_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            if (beat && stat_words != 16'hFFFF) begin
                stat_words <= stat_words + 16'd1;
            end
            if (bus.m_valid && !bus.m_ready && stat_stall != 16'hFFFF) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised and directed bench for fifo_stream_reader against a queue-based FIFO/stream model.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int PL = DEF_PKT_LEN;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic idle;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_stall;
`endif

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus),
        .idle  (idle)
`ifdef FIFO_STREAM_READER_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_stall (stat_stall)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] popped_q[$];
    int            beat_cnt  = 0;
    int            pops_rst  = 0;
    int            exp_words = 0;
    int            exp_stall = 0;
    bit            t_pop, t_beat, t_last;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW-1:0] next_w;
    int            first_pop, first_beat, last_beat, first_last, nb, np, inj;
    logic [7:0]    last_mask;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample just after the input-drive point, update the models, advance to next negedge.
    task automatic tick();
        logic [DW-1:0] got_word;
        logic [DW-1:0] exp_word;
        got_word = '0;
        bus.fifo_empty = (fifo_q.size() == 0);
        #1;
        t_pop  = bus.fifo_rd_en && !bus.fifo_empty;
        t_beat = bus.m_valid && bus.m_ready;
        t_last = bus.m_last;
        if (bus.fifo_empty) chk("no_rd_when_empty", 32'(bus.fifo_rd_en), 32'd0);
        if (!bus.m_valid) chk("last_needs_valid", 32'(bus.m_last), 32'd0);
        if (prev_hold) begin
            chk("hold_valid", 32'(bus.m_valid), 32'd1);
            chk("hold_data", 32'(bus.m_data), 32'(prev_data));
            chk("hold_last", 32'(bus.m_last), 32'(prev_last));
        end
        prev_hold = rst_n && bus.m_valid && !bus.m_ready;
        prev_data = bus.m_data;
        prev_last = bus.m_last;
        if (bus.m_valid) chk("valid_has_source", 32'(popped_q.size() > 0), 32'd1);
        if (t_beat && popped_q.size() > 0) begin
            exp_word = popped_q.pop_front();
            chk("beat_data", 32'(bus.m_data), 32'(exp_word));
            chk("beat_last", 32'(bus.m_last), 32'((beat_cnt % PL) == PL - 1));
            beat_cnt++;
        end
        if (t_pop) begin
            got_word = fifo_q.pop_front();
            if (rst_n) begin
                popped_q.push_back(got_word);
                pops_rst++;
            end
        end
        if (rst_n) begin
            chk("outstanding_le2", 32'(popped_q.size() <= 2), 32'd1);
            if (t_beat && exp_words < 65535) exp_words++;
            if (bus.m_valid && !bus.m_ready && exp_stall < 65535) exp_stall++;
        end else begin
            popped_q.delete();
            beat_cnt  = 0;
            pops_rst  = 0;
            exp_words = 0;
            exp_stall = 0;
        end
        @(posedge clk);
        @(negedge clk);
        bus.fifo_d_out = t_pop ? got_word : DW'($urandom);
        bus.fifo_empty = (fifo_q.size() == 0);
`ifdef FIFO_STREAM_READER_STATS_EN
        chk("stat_words_model", 32'(stat_words), 32'(exp_words));
        chk("stat_stall_model", 32'(stat_stall), 32'(exp_stall));
`endif
    endtask

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) begin
            fifo_q.push_back(next_w);
            next_w = next_w + DW'(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_d_out = '0;
        bus.m_ready    = 1'b0;
        rst_n  = 1'b0;
        en     = 1'b1;
        next_w = DW'(1);
        push_words(8);
        @(negedge clk);

        // reset held with en high and a non-empty FIFO
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
            chk("rst_valid", 32'(bus.m_valid), 32'd0);
            chk("rst_last", 32'(bus.m_last), 32'd0);
            chk("rst_data", 32'(bus.m_data), 32'd0);
            chk("rst_idle", 32'(idle), 32'd1);
        end
        chk("rst_fifo_untouched", 32'(fifo_q.size()), 32'd8);

        // streaming 1..8
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        first_pop = -1; first_beat = -1; last_beat = -1; nb = 0; last_mask = '0;
        for (int i = 0; i < 30 && nb < 8; i++) begin
            tick();
            if (t_pop && first_pop < 0) first_pop = i;
            if (t_beat) begin
                if (first_beat < 0) first_beat = i;
                last_beat = i;
                if (t_last) last_mask[nb] = 1'b1;
                nb++;
            end
        end
        chk("stream_beats", 32'(nb), 32'd8);
        chk("stream_en_to_rd", 32'(first_pop), 32'd1);
        chk("stream_latency", 32'(first_beat - first_pop), 32'd2);
        chk("stream_back2back", 32'(last_beat - first_beat), 32'd7);
        chk("stream_last_mask", 32'(last_mask), 32'h88);

        // backpressure 9..16
        bus.m_ready = 1'b0;
        push_words(8);
        np = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (t_pop) np++;
        end
        chk("bp_pops", 32'(np), 32'd2);
        chk("bp_valid", 32'(bus.m_valid), 32'd1);
        chk("bp_head", 32'(bus.m_data), 32'd9);
        bus.m_ready = 1'b1;
        nb = 0;
        for (int i = 0; i < 40 && nb < 8; i++) begin
            tick();
            if (t_beat) nb++;
        end
        chk("bp_beats", 32'(nb), 32'd8);
        chk("bp_fifo_empty", 32'(fifo_q.size()), 32'd0);

        // graceful stop after the second pop of a packet
        push_words(8);
        np = 0; nb = 0;
        for (int i = 0; i < 20 && np < 2; i++) begin
            tick();
            if (t_pop) np++;
            if (t_beat) nb++;
        end
        en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (t_pop) np++;
            if (t_beat) nb++;
            if (idle) break;
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (t_pop) np++;
        end
        chk("stop_pops", 32'(np), 32'd4);
        chk("stop_beats", 32'(nb), 32'd4);
        chk("stop_idle", 32'(idle), 32'd1);
        chk("stop_fifo_left", 32'(fifo_q.size()), 32'd4);

        // reset with the buffer full
        push_words(8);
        en = 1'b1;
        bus.m_ready = 1'b0;
        np = 0;
        for (int i = 0; i < 20 && np < 2; i++) begin
            tick();
            if (t_pop) np++;
        end
        tick();
        tick();
        chk("midrst_pre_valid", 32'(bus.m_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(bus.m_valid), 32'd0);
        chk("midrst_idle", 32'(idle), 32'd1);
        chk("midrst_fifo_kept", 32'(fifo_q.size()), 32'd10);
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        nb = 0; first_last = 0;
        for (int i = 0; i < 40 && nb < 10; i++) begin
            tick();
            if (t_beat) begin
                nb++;
                if (t_last && first_last == 0) first_last = nb;
            end
        end
        chk("midrst_beats", 32'(nb), 32'd10);
        chk("midrst_first_last", 32'(first_last), 32'd4);

        // randomised traffic with en toggles and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            bus.m_ready = ($urandom_range(0, 3) != 0);
            if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) push_words(1);
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end

        // wind down: feed data until the current packet completes, then expect IDLE
        rst_n = 1'b1;
        en = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (fifo_q.size() == 0) push_words(1);
            tick();
            if (idle && popped_q.size() == 0) break;
        end
        chk("final_idle", 32'(idle), 32'd1);
        chk("final_drained", 32'(popped_q.size()), 32'd0);
        chk("final_pkt_align", 32'(pops_rst % PL), 32'd0);
        chk("final_beat_align", 32'(beat_cnt % PL), 32'd0);

`ifdef FIFO_STREAM_READER_STATS_EN
        // 8 beats with 3 injected stall cycles
        rst_n = 1'b0;
        fifo_q.delete();
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        push_words(8);
        nb = 0; inj = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.m_valid && inj < 3 && nb >= 2) begin
                bus.m_ready = 1'b0;
                inj++;
            end else begin
                bus.m_ready = 1'b1;
            end
            tick();
            if (t_beat) nb++;
        end
        chk("stats_beats", 32'(nb), 32'd8);
        chk("stats_words", 32'(stat_words), 32'd8);
        chk("stats_stall", 32'(stat_stall), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
